// File: rtl/early_db_pkg.sv
// Shared types and helpers for the early-detection debouncer.
package early_db_pkg;

   typedef enum logic [1:0] {
      ZERO  = 2'd0,
      WAIT1 = 2'd1,
      ONE   = 2'd2,
      WAIT0 = 2'd3
   } db_state_e;

   // Bits needed to hold LOCK_TICKS-1 (at least one bit).
   function automatic int unsigned cnt_width(input int unsigned lock_ticks);
      int unsigned w;
      w = 1;
      while (((32'd1 << w) < lock_ticks) && (w < 32'd31)) begin
         w = w + 32'd1;
      end
      return w;
   endfunction

endpackage

// File: rtl/early_db_channel.sv
// One debounce channel: 2-flop synchroniser, edge-first FSM and lockout counter.
module early_db_channel
   import early_db_pkg::*;
#(
   parameter int unsigned LOCK_TICKS = 2_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic i_in,
   input  logic i_en,
   output logic o_out,
   output logic o_rise_tick,
   output logic o_fall_tick,
   output logic o_busy
);

   localparam int unsigned      CNT_W    = cnt_width(LOCK_TICKS);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(LOCK_TICKS - 32'd1);

   logic             r_s1;
   logic             r_s2;
   db_state_e        r_state;
   db_state_e        w_state_nxt;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] w_cnt_nxt;
   logic             w_rise;
   logic             w_fall;
   logic             w_out_nxt;
   logic             w_busy_nxt;
   logic             r_out;
   logic             r_rise;
   logic             r_fall;
   logic             r_busy;

   // Synchroniser runs regardless of enable.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_s1 <= 1'b0;
         r_s2 <= 1'b0;
      end else begin
         r_s1 <= i_in;
         r_s2 <= r_s1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ZERO;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next state; a disabled channel simply keeps its state and count.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_rise      = 1'b0;
      w_fall      = 1'b0;
      if (i_en) begin
         unique case (r_state)
            ZERO: begin
               if (r_s2) begin
                  w_state_nxt = WAIT1;
                  w_cnt_nxt   = CNT_LOAD;
                  w_rise      = 1'b1;
               end
            end
            WAIT1: begin
               if (r_cnt == '0) begin
                  w_state_nxt = ONE;
               end else begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end
            end
            ONE: begin
               if (!r_s2) begin
                  w_state_nxt = WAIT0;
                  w_cnt_nxt   = CNT_LOAD;
                  w_fall      = 1'b1;
               end
            end
            WAIT0: begin
               if (r_cnt == '0) begin
                  w_state_nxt = ZERO;
               end else begin
                  w_cnt_nxt = r_cnt - CNT_W'(1);
               end
            end
            default: begin
               w_state_nxt = ZERO;
               w_cnt_nxt   = '0;
            end
         endcase
      end
   end

   assign w_out_nxt  = (w_state_nxt == WAIT1) || (w_state_nxt == ONE);
   assign w_busy_nxt = (w_state_nxt == WAIT1) || (w_state_nxt == WAIT0);

   // Outputs registered from the next state so they change with it.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_out  <= 1'b0;
         r_rise <= 1'b0;
         r_fall <= 1'b0;
         r_busy <= 1'b0;
      end else begin
         r_out  <= w_out_nxt;
         r_rise <= w_rise;
         r_fall <= w_fall;
         r_busy <= w_busy_nxt;
      end
   end

   assign o_out       = r_out;
   assign o_rise_tick = r_rise;
   assign o_fall_tick = r_fall;
   assign o_busy      = r_busy;

endmodule

// File: rtl/multi_early_debounce.sv
// N_CH independent early-detection debounce channels.
module multi_early_debounce #(
   parameter int unsigned N_CH       = 4,
   parameter int unsigned LOCK_TICKS = 2_000_000
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N_CH-1:0] in,
   input  logic [N_CH-1:0] en,
   output logic [N_CH-1:0] out,
   output logic [N_CH-1:0] rise_tick,
   output logic [N_CH-1:0] fall_tick,
   output logic [N_CH-1:0] busy
);

   for (genvar g = 0; g < int'(N_CH); g++) begin : g_ch
      early_db_channel #(
         .LOCK_TICKS(LOCK_TICKS)
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .i_in        (in[g]),
         .i_en        (en[g]),
         .o_out       (out[g]),
         .o_rise_tick (rise_tick[g]),
         .o_fall_tick (fall_tick[g]),
         .o_busy      (busy[g])
      );
   end

endmodule

// File: doc/multi_early_debounce.md
Name: multi_early_debounce

Overview:
- Multi-channel, early-detection switch/button debouncer.
- Each channel propagates the first observed input edge to its output immediately, then ignores the input for a lockout window.
- Adds per-channel enable, a busy (lockout) flag and single-cycle rise/fall tick pulses.
- Sits between raw board inputs and the FSMD control logic that consumes clean levels and edge events.

Parameters:
- N_CH, 4, number of independent debounce channels.
- LOCK_TICKS, 2_000_000, lockout length in clk cycles (20 ms at 100 MHz); must be >= 2.
- CNT_W, $clog2(LOCK_TICKS), lockout counter width (derived localparam, not overridable).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- in  input  N_CH  raw asynchronous inputs, one bit per channel.
- en  input  N_CH  per-channel enable; 0 freezes that channel.
- out  output  N_CH  debounced levels.
- rise_tick  output  N_CH  1-cycle pulse when out goes 0->1.
- fall_tick  output  N_CH  1-cycle pulse when out goes 1->0.
- busy  output  N_CH  1 while the channel is in lockout.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (ports clk, reset). While reset is high: out=0, rise_tick=0, fall_tick=0, busy=0, synchroniser flops=0, counters=0, FSM=ZERO.
- Synchroniser: each in bit passes through 2 flops (s1, s2); the FSM sees s2 only.
- FSM per channel: ZERO, WAIT1, ONE, WAIT0 (encoded enum). out=1 in WAIT1 and ONE; busy=1 in WAIT1 and WAIT0.
  - ZERO: if s2=1, go to WAIT1, load cnt=LOCK_TICKS-1, assert rise_tick for that cycle.
  - WAIT1: input ignored. If cnt==0 go to ONE, else cnt--. WAIT1 occupies exactly LOCK_TICKS cycles.
  - ONE: if s2=0, go to WAIT0, load cnt, assert fall_tick.
  - WAIT0: mirror of WAIT1, exits to ZERO.
- Latency: an in change that meets setup before edge k appears on out after edge k+2 (3 clock edges). Ticks are registered and coincide with the out change.
- Minimum out pulse width: LOCK_TICKS+1 cycles, because the FSM spends at least one cycle in ONE/ZERO before it can re-evaluate.
- Lockout exit: if the input already differs from out when lockout ends (e.g. a release during lockout), the opposite transition occurs one cycle after the exit. No event is lost if the input level persists.
- en=0: FSM state, cnt and out hold; ticks forced 0; the synchroniser keeps running. On re-enable, evaluation resumes from the held state.
- Channels are fully independent; simultaneous events on several channels are all reported in the same cycle.
- Reset mid-lockout: out drops to 0 asynchronously, with no fall_tick. After reset release, a held-high input produces a fresh rise after 3 edges.
- Counter width: cnt is CNT_W bits and never wraps; decrement occurs only when cnt!=0.

Decomposition:
- Package early_db_pkg: state enum (ZERO, WAIT1, ONE, WAIT0) and a function returning the counter width for a given LOCK_TICKS.
- Sub-module early_db_channel: single-channel synchroniser + FSM + counter.
- Top level instantiates N_CH copies in a generate loop.

Test Plan (LOCK_TICKS=16, N_CH=4, 10 ns clk):
- Reset high 5 ns then low, in=0 -> all outputs 0; no ticks for 50 cycles.
- ch0 bounce: in[0] 1/0/1/0/1 at 2-cycle intervals, then held 1 -> rise_tick[0] exactly once, 3 edges after the first 1; out[0]=1 continuously for 17+ cycles; busy[0]=1 for exactly 16 cycles.
- ch0 release during lockout: in[0]=0 at cycle 5 of lockout -> out[0] stays 1 until lockout ends, falls 1 cycle after ONE entry; one fall_tick[0].
- Simultaneous: in[3:0]=4'b1111 on the same edge -> rise_tick=4'b1111 in the same cycle; out=4'b1111.
- en[1]=0 mid-WAIT1 for 10 cycles -> busy[1] and out[1] hold; lockout extends by 10 cycles; no ticks while disabled.
- reset pulse during WAIT1 on ch2 -> out[2]=0 immediately (asynchronous); no fall_tick; held in[2]=1 re-rises 3 edges after reset release.
